vector_lane_serializer: RTL
===========================

VECTOR_LANE_SERIALIZER -- requirements
Module: vector_lane_serializer

Interface
REQ-001 SHALL have parameter LANES, default 4, number of 32-bit lanes per vector; only 4 is supported.
REQ-002 SHALL have parameter W, default 32, lane width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port vec_valid, input, 1 bit: the upstream vector is valid.
REQ-006 SHALL have port vec_ready, output, 1 bit: the block can accept a vector.
REQ-007 SHALL have port vec_data, input, 128 bits: lane i is at bits [32i+31:32i].
REQ-008 SHALL have port lane_mask, input, 4 bits: bit i set means lane i is emitted; sampled with vec_data.
REQ-009 SHALL have port sc_valid, output, 1 bit: the scalar output is valid.
REQ-010 SHALL have port sc_ready, input, 1 bit: downstream accepts the scalar.
REQ-011 SHALL have port sc_data, output, 32 bits: the emitted lane value.
REQ-012 SHALL have port sc_lane, output, 2 bits: the index of the emitted lane.
REQ-013 SHALL have port sc_last, output, 1 bit: marks the final emitted lane of the current vector.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state is EMIT.

Function
REQ-015 SHALL implement FSM states IDLE and EMIT.
REQ-016 A vector transfer SHALL occur on any cycle where vec_valid and vec_ready are both high.
REQ-017 A scalar transfer SHALL occur on any cycle where sc_valid and sc_ready are both high.
REQ-018 On a vector transfer with lane_mask != 0, the block SHALL register vec_data and lane_mask into work registers and enter EMIT next cycle.
REQ-019 On a vector transfer with lane_mask == 0, the block SHALL consume and drop the vector, produce no scalar, and leave state unchanged.
REQ-020 In EMIT, sc_valid SHALL be high, sc_lane SHALL be the lowest set bit of the pending mask, and sc_data SHALL be that lane of the work register.
REQ-021 On each scalar transfer, the block SHALL clear the emitted bit from the pending mask.
REQ-022 sc_last SHALL be high exactly when the pending mask has one bit set.
REQ-023 On a scalar transfer with sc_last high, state SHALL return to IDLE unless REQ-033 applies.
REQ-024 While sc_valid is high and sc_ready is low, sc_data, sc_lane and sc_last SHALL hold stable.
REQ-025 Latency SHALL be 1 cycle from vector transfer to first sc_valid.
REQ-026 Throughput SHALL be one lane per cycle while sc_ready is held high.
REQ-027 Lanes SHALL be emitted in ascending index order; unset lanes SHALL be skipped with no bubble cycle.
REQ-028 In IDLE, sc_valid and sc_last SHALL be 0; sc_data and sc_lane are don't-care but SHALL be driven as 0.
REQ-029 Without REQ-033, vec_ready SHALL equal (state == IDLE).

Reset
REQ-030 rst high SHALL asynchronously force IDLE, clear pending mask and work data, and drive vec_ready=0, sc_valid=0, sc_last=0, sc_data=0, sc_lane=0, busy=0 while asserted.
REQ-031 After rst deasserts, vec_ready SHALL be 1 on the first clock edge.
REQ-032 Reset mid-EMIT SHALL discard the remaining lanes; no partial emission SHALL resume.

Configuration
REQ-033 If macro VECTOR_SERIALIZER_SKID_EN is defined, the block SHALL add one holding entry with the following behaviour:
- vec_ready = (IDLE) or (EMIT and holding entry empty).
- A nonzero-mask vector accepted during EMIT SHALL be stored in the holding entry.
- On the sc_last transfer with the holding entry full, the holding entry SHALL move to the work registers and state SHALL stay EMIT, giving zero bubble cycles between vectors.
REQ-034 If VECTOR_SERIALIZER_SKID_EN is undefined, there SHALL be no holding entry, REQ-029 SHALL apply, and there SHALL be one IDLE cycle between back-to-back vectors.

Verification
REQ-035 Scenario: vec_data=0x44443333_22221111_... , mask=4'b1111, sc_ready=1 -> lanes 0,1,2,3 emitted on 4 consecutive cycles starting 1 cycle after transfer; sc_last on lane 3 only.
REQ-036 Scenario: mask=4'b1010 -> exactly two beats, sc_lane=1 then sc_lane=3 (sc_last=1 on lane 3), no bubble between them.
REQ-037 Scenario: mask=4'b0000 with vec_valid=1 -> vec_ready stays 1, sc_valid never asserts, busy stays 0.
REQ-038 Scenario: sc_ready toggles 1,0,0,1 during a mask=4'b0111 vector -> outputs stable during stall; all 3 lanes delivered in order.
REQ-039 Scenario: rst pulsed asynchronously between clock edges after 2 of 4 lanes emitted -> outputs clear immediately; the next vector emits from its own lane 0.
REQ-040 Scenario: with VECTOR_SERIALIZER_SKID_EN, two back-to-back full-mask vectors -> 8 consecutive sc_valid beats; without the macro -> a 1-cycle gap after beat 4.

Source files
------------

// File: rtl/vector_lane_serializer.sv
// Vector-to-scalar lane serializer: accepts a LANES x W vector plus lane mask
// and emits the selected lanes one per cycle in ascending order.
// Optional one-entry skid buffer for zero-bubble back-to-back vectors: VECTOR_SERIALIZER_SKID_EN.
module vector_lane_serializer #(
  parameter int LANES = 4,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vec_valid,
  output logic                       vec_ready,
  input  logic [LANES*W-1:0]         vec_data,
  input  logic [LANES-1:0]           lane_mask,
  output logic                       sc_valid,
  input  logic                       sc_ready,
  output logic [W-1:0]               sc_data,
  output logic [$clog2(LANES)-1:0]   sc_lane,
  output logic                       sc_last,
  output logic                       busy
);

  localparam int LW = $clog2(LANES);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  localparam logic [LANES-1:0] ZERO_M = {LANES{1'b0}};
  localparam logic [LANES-1:0] ONE_M  = {{(LANES-1){1'b0}}, 1'b1};

  function automatic logic [LW-1:0] lowest_lane(input logic [LANES-1:0] m);
    logic [LW-1:0] l;
    l = {LW{1'b0}};
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) begin
        l = LW'(i);
      end else begin
        l = l;
      end
    end
    return l;
  endfunction

  function automatic logic single_bit(input logic [LANES-1:0] m);
    return (m != ZERO_M) && ((m & (m - ONE_M)) == ZERO_M);
  endfunction

  function automatic logic [W-1:0] lane_word(input logic [LANES*W-1:0] d,
                                             input logic [LW-1:0]      l);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (l == LW'(i)) begin
        r = d[i*W +: W];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic [0:0]          state_r, state_s;
  logic [LANES*W-1:0]  work_data_r, work_data_s;
  logic [LANES-1:0]    pend_mask_r, pend_mask_s;
  logic                vec_ready_r, vec_ready_s;
  logic                sc_valid_r;
  logic [W-1:0]        sc_data_r;
  logic [LW-1:0]       sc_lane_r;
  logic                sc_last_r;
  logic                busy_r;
  logic                vec_fire_s;
  logic                vec_live_s;
  logic                sc_fire_s;
  logic [LW-1:0]       next_lane_s;
`ifdef VECTOR_SERIALIZER_SKID_EN
  logic [LANES*W-1:0]  hold_data_r, hold_data_s;
  logic [LANES-1:0]    hold_mask_r, hold_mask_s;
  logic                hold_valid_r, hold_valid_s;
`endif

  // Next-state, work-register and pending-mask update from the two handshakes
  always_comb begin
    state_s     = state_r;
    work_data_s = work_data_r;
    pend_mask_s = pend_mask_r;
`ifdef VECTOR_SERIALIZER_SKID_EN
    hold_data_s  = hold_data_r;
    hold_mask_s  = hold_mask_r;
    hold_valid_s = hold_valid_r;
`endif
    vec_fire_s = vec_valid & vec_ready_r;
    vec_live_s = vec_fire_s & (lane_mask != ZERO_M);
    sc_fire_s  = sc_valid_r & sc_ready;

    case (state_r)
      IDLE: begin
        if (vec_live_s) begin
          work_data_s = vec_data;
          pend_mask_s = lane_mask;
          state_s     = EMIT;
        end else begin
          state_s = IDLE;
        end
      end
      EMIT: begin
        if (sc_fire_s) begin
          pend_mask_s = pend_mask_r & ~(ONE_M << sc_lane_r);
          if (sc_last_r) begin
`ifdef VECTOR_SERIALIZER_SKID_EN
            // Chain straight into the next vector so the beat stream never gaps
            if (hold_valid_r) begin
              work_data_s  = hold_data_r;
              pend_mask_s  = hold_mask_r;
              hold_valid_s = 1'b0;
              state_s      = EMIT;
            end else if (vec_live_s) begin
              work_data_s = vec_data;
              pend_mask_s = lane_mask;
              state_s     = EMIT;
            end else begin
              state_s = IDLE;
            end
`else
            state_s = IDLE;
`endif
          end else begin
            state_s = EMIT;
          end
        end else begin
          state_s = EMIT;
        end
`ifdef VECTOR_SERIALIZER_SKID_EN
        if (vec_live_s && !(sc_fire_s && sc_last_r && !hold_valid_r)) begin
          hold_data_s  = vec_data;
          hold_mask_s  = lane_mask;
          hold_valid_s = 1'b1;
        end else begin
          hold_valid_s = hold_valid_s;
        end
`endif
      end
      default: begin
        state_s     = IDLE;
        pend_mask_s = ZERO_M;
      end
    endcase

`ifdef VECTOR_SERIALIZER_SKID_EN
    vec_ready_s = (state_s == IDLE) || !hold_valid_s;
`else
    vec_ready_s = (state_s == IDLE);
`endif
    next_lane_s = lowest_lane(pend_mask_s);
  end

  // State and work registers; outputs are registered from next-state values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      work_data_r <= {(LANES*W){1'b0}};
      pend_mask_r <= ZERO_M;
      vec_ready_r <= 1'b0;
      sc_valid_r  <= 1'b0;
      sc_data_r   <= {W{1'b0}};
      sc_lane_r   <= {LW{1'b0}};
      sc_last_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      work_data_r <= work_data_s;
      pend_mask_r <= pend_mask_s;
      vec_ready_r <= vec_ready_s;
      if (state_s == EMIT) begin
        sc_valid_r <= 1'b1;
        sc_data_r  <= lane_word(work_data_s, next_lane_s);
        sc_lane_r  <= next_lane_s;
        sc_last_r  <= single_bit(pend_mask_s);
        busy_r     <= 1'b1;
      end else begin
        sc_valid_r <= 1'b0;
        sc_data_r  <= {W{1'b0}};
        sc_lane_r  <= {LW{1'b0}};
        sc_last_r  <= 1'b0;
        busy_r     <= 1'b0;
      end
    end
  end

`ifdef VECTOR_SERIALIZER_SKID_EN
  // Holding entry for a vector accepted while the current one is still emitting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data_r  <= {(LANES*W){1'b0}};
      hold_mask_r  <= ZERO_M;
      hold_valid_r <= 1'b0;
    end else begin
      hold_data_r  <= hold_data_s;
      hold_mask_r  <= hold_mask_s;
      hold_valid_r <= hold_valid_s;
    end
  end
`endif

  assign vec_ready = vec_ready_r;
  assign sc_valid  = sc_valid_r;
  assign sc_data   = sc_data_r;
  assign sc_lane   = sc_lane_r;
  assign sc_last   = sc_last_r;
  assign busy      = busy_r;

endmodule
